// File: rtl/irq_sequencer_pkg.sv
// Shared constants for the TV80 interrupt sequencer: register map, FSM states
// and the RST opcode base used to build acknowledge vectors.
package irq_pkg;

  localparam logic [1:0] IRQ_REG_MASK = 2'd0;
  localparam logic [1:0] IRQ_REG_PEND = 2'd1;
  localparam logic [1:0] IRQ_REG_ISR  = 2'd2;
  localparam logic [1:0] IRQ_REG_EDGE = 2'd3;

  // RST 00h opcode; line n becomes RST n*8
  localparam logic [7:0] IRQ_RST_BASE = 8'hC7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    ACK     = 2'd2,
    SERVICE = 2'd3
  } irq_state_e;

  function automatic logic [7:0] irq_vector(input logic [2:0] idx);
    return IRQ_RST_BASE | {2'b00, idx, 3'b000};
  endfunction

endpackage

// File: rtl/irq_sequencer_if.sv
// CPU-side bus of the interrupt sequencer: TV80 M1/IORQ, the I/O register
// window strobes, and the two outputs back to the CPU.
interface irq_sequencer_if;
  logic       m1_n;
  logic       iorq_n;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic [1:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       int_n;

  modport master (
    output m1_n, iorq_n, cs_n, rd_n, wr_n, addr, data_in,
    input  data_out, int_n
  );

  modport slave (
    input  m1_n, iorq_n, cs_n, rd_n, wr_n, addr, data_in,
    output data_out, int_n
  );
endinterface

// File: rtl/irq_sequencer_prio_enc.sv
// Fixed-priority encoder: bit 0 wins. Gives the winning index and its RST vector.
module irq_prio_enc
  import irq_pkg::*;
(
  input  logic [7:0] req,
  output logic       valid,
  output logic [2:0] idx,
  output logic [7:0] vec
);

  // Scan from the lowest priority up so the last hit is the highest priority
  always_comb begin
    valid = 1'b0;
    idx   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = 3'(i);
      end
    end
    vec = irq_vector(idx);
  end

endmodule

// File: rtl/irq_sequencer.sv
// TV80 mode-0 interrupt sequencer: synchronizes and latches requests, applies
// mask and fixed priority, answers INTA with an RST opcode and tracks
// in-service lines until EOI.
// Optional build macro IRQ_SEQUENCER_NESTED_EN lets a strictly higher-priority
// request preempt a line that is in service.
module irq_sequencer
  import irq_pkg::*;
#(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  irq_sequencer_if.slave     bus
);

  localparam logic [7:0] LINE_MASK = 8'((16'd1 << NUM_IRQ) - 16'd1);

  logic [SYNC_STAGES-1:0][7:0] sync_q;
  logic [7:0] irq_s, irq_d, irq_ext;
  logic [7:0] mask, pending, isr, edge_cfg, active;
  logic [7:0] set_vec, pend_clr, isr_nxt, dout;
  logic [7:0] act_vec, win_vec;
  logic [2:0] act_idx, win_idx;
  logic       act_valid, req_ok, inta, rd_en, wr_lvl, wr_q, wr_stb, ack_done, eoi;
  logic       int_q;
  irq_state_e state;

  assign irq_ext  = 8'(irq_in);
  assign irq_s    = sync_q[SYNC_STAGES-1];
  assign inta     = ~bus.m1_n & ~bus.iorq_n;
  assign rd_en    = ~bus.cs_n & ~bus.rd_n;
  assign wr_lvl   = ~bus.cs_n & ~bus.wr_n;
  assign wr_stb   = wr_lvl & ~wr_q;
  assign active   = pending & ~mask;
  assign ack_done = (state == ACK) & bus.iorq_n;
  assign eoi      = wr_stb & (bus.addr == IRQ_REG_ISR) & (isr != 8'd0);

  // Level lines pend while high; edge lines only on a synchronized rise
  assign set_vec  = irq_s & ~(edge_cfg & irq_d) & LINE_MASK;
  assign pend_clr = ((wr_stb && bus.addr == IRQ_REG_PEND) ? bus.data_in : 8'd0)
                  | (ack_done ? (8'd1 << win_idx) : 8'd0);

  irq_prio_enc u_act_enc (
    .req   (active),
    .valid (act_valid),
    .idx   (act_idx),
    .vec   (act_vec)
  );

`ifdef IRQ_SEQUENCER_NESTED_EN
  logic       isr_valid;
  logic [2:0] isr_idx;
  logic [7:0] isr_vec;

  irq_prio_enc u_isr_enc (
    .req   (isr),
    .valid (isr_valid),
    .idx   (isr_idx),
    .vec   (isr_vec)
  );

  // Vectors grow with index, so comparing them orders priority as well
  assign req_ok = act_valid & (~isr_valid | ((act_idx < isr_idx) & (act_vec < isr_vec)));
`else
  assign req_ok = act_valid & (isr == 8'd0);
`endif

  // Next in-service set: EOI drops the highest-priority bit, ACK adds the winner
  always_comb begin
    isr_nxt = isr;
    if (eoi)      isr_nxt = isr & (isr - 8'd1);
    if (ack_done) isr_nxt[win_idx] = 1'b1;
  end

  // Synchronizers, request latching and the software-visible registers
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      irq_d    <= 8'd0;
      wr_q     <= 1'b0;
      mask     <= 8'hFF & LINE_MASK;
      pending  <= 8'd0;
      isr      <= 8'd0;
      edge_cfg <= 8'd0;
    end else begin
      sync_q[0] <= irq_ext;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      irq_d   <= irq_s;
      wr_q    <= wr_lvl;
      pending <= (pending & ~pend_clr) | set_vec;
      isr     <= isr_nxt;
      if (wr_stb) begin
        case (bus.addr)
          IRQ_REG_MASK: mask     <= bus.data_in & LINE_MASK;
          IRQ_REG_EDGE: edge_cfg <= bus.data_in & LINE_MASK;
          default: ;
        endcase
      end
    end
  end

  // Request/acknowledge sequencing; int_n is registered here
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      int_q   <= 1'b1;
      win_idx <= 3'd0;
      win_vec <= 8'd0;
    end else begin
      case (state)
        IDLE: if (req_ok) begin
          state <= REQ;
          int_q <= 1'b0;
        end
        REQ: if (!req_ok) begin
          state <= (isr != 8'd0) ? SERVICE : IDLE;
          int_q <= 1'b1;
        end else if (inta) begin
          win_idx <= act_idx;
          win_vec <= act_vec;
          state   <= ACK;
          int_q   <= 1'b1;
        end
        ACK: if (bus.iorq_n) state <= SERVICE;
        SERVICE: begin
          if (isr_nxt == 8'd0) state <= IDLE;
`ifdef IRQ_SEQUENCER_NESTED_EN
          else if (req_ok) begin
            state <= REQ;
            int_q <= 1'b0;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  // OR-bus read data: INTA vector first, then register reads, else zero
  always_comb begin
    dout = 8'd0;
    if (inta) begin
      case (state)
        REQ:     dout = act_vec;
        ACK:     dout = win_vec;
        default: dout = 8'hFF;
      endcase
    end else if (rd_en) begin
      case (bus.addr)
        IRQ_REG_MASK: dout = mask;
        IRQ_REG_PEND: dout = pending;
        IRQ_REG_ISR:  dout = isr;
        default:      dout = edge_cfg;
      endcase
    end
  end

  assign bus.data_out = dout;
  assign bus.int_n    = int_q;

endmodule
